// File: rtl/trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trace_capture_buffer
// Description : Armable circular trace buffer for pc/inst/writeback records,
//               with PC-match trigger, post-trigger window and freeze.
//               Optional macro TRACE_RANGE_EN adds an rng_lo..rng_hi PC filter.
// Revision    : 1.0 - initial release
// ============================================================================
module trace_capture_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic [AW:0]       post_cnt,
    input  logic              cap_valid,
    input  logic [DATA_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_inst,
    input  logic [DATA_W-1:0] cap_wdata,
`ifdef TRACE_RANGE_EN
    input  logic [DATA_W-1:0] rng_lo,
    input  logic [DATA_W-1:0] rng_hi,
`endif
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_inst,
    output logic [DATA_W-1:0] rd_wdata,
    output logic [1:0]        state,
    output logic [AW:0]       count,
    output logic              triggered
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PRE  = 2'b01,
        S_POST = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_max_post = (AW+1)'(DEPTH-1);
    localparam logic [AW:0]   c_cnt_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one  = AW'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AW-1:0]       r_wr_ptr;
    logic [AW:0]         r_count;
    logic [AW-1:0]       r_post_left;
    logic                r_triggered;
    logic [3*DATA_W-1:0] r_mem [DEPTH];

    logic                w_in_range;
    logic                w_accept;
    logic                w_trig;
    logic                w_post_last;
    logic [AW-1:0]       w_post_clamp;
    logic [AW-1:0]       w_rd_phys;

`ifdef TRACE_RANGE_EN
    assign w_in_range = (cap_pc >= rng_lo) && (cap_pc <= rng_hi);
`else
    assign w_in_range = 1'b1;
`endif

    // arm wins over any record offered in the same cycle
    assign w_accept     = cap_valid && w_in_range && !arm &&
                          ((r_state == S_PRE) || (r_state == S_POST));
    assign w_trig       = w_accept && (r_state == S_PRE) && (cap_pc == trig_pc);
    assign w_post_last  = (r_state == S_POST) && w_accept && (r_post_left == c_ptr_one);
    // capping at DEPTH-1 keeps the trigger record from being overwritten
    assign w_post_clamp = (post_cnt > c_max_post) ? c_max_post[AW-1:0] : post_cnt[AW-1:0];
    assign w_rd_phys    = r_wr_ptr - r_count[AW-1:0] + rd_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (arm) begin
            w_state_nxt = S_PRE;
        end else begin
            case (r_state)
                S_PRE: begin
                    if (w_trig) begin
                        w_state_nxt = (w_post_clamp == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (w_post_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_left <= '0;
            r_triggered <= 1'b0;
        end else if (arm) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_left <= '0;
            r_triggered <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (r_count != c_depth) begin
                r_count <= r_count + c_cnt_one;
            end
            if (w_trig) begin
                r_triggered <= 1'b1;
                r_post_left <= w_post_clamp;
            end else if (r_state == S_POST) begin
                r_post_left <= r_post_left - c_ptr_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {cap_pc, cap_inst, cap_wdata};
        end
    end

    // same-entry read/write returns the pre-write contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pc    <= '0;
            rd_inst  <= '0;
            rd_wdata <= '0;
        end else begin
            {rd_pc, rd_inst, rd_wdata} <= r_mem[w_rd_phys];
        end
    end

    assign state     = r_state;
    assign count     = r_count;
    assign triggered = r_triggered;

endmodule
`default_nettype wire

// File: tb/tb_trace_capture_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_trace_capture_buffer
// Description : Directed self-checking bench for trace_capture_buffer, DEPTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trace_capture_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AW     = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic [DATA_W-1:0] trig_pc;
    logic [AW:0]       post_cnt;
    logic              cap_valid;
    logic [DATA_W-1:0] cap_pc;
    logic [DATA_W-1:0] cap_inst;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rng_lo;
    logic [DATA_W-1:0] rng_hi;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_inst;
    logic [DATA_W-1:0] rd_wdata;
    logic [1:0]        state;
    logic [AW:0]       count;
    logic              triggered;

    int n_tests = 0;
    int n_fail  = 0;

    trace_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .arm       (arm),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .cap_valid (cap_valid),
        .cap_pc    (cap_pc),
        .cap_inst  (cap_inst),
        .cap_wdata (cap_wdata),
`ifdef TRACE_RANGE_EN
        .rng_lo    (rng_lo),
        .rng_hi    (rng_hi),
`endif
        .rd_addr   (rd_addr),
        .rd_pc     (rd_pc),
        .rd_inst   (rd_inst),
        .rd_wdata  (rd_wdata),
        .state     (state),
        .count     (count),
        .triggered (triggered)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rec_pc(input int k);
        return 32'h0040_0000 + 32'(4 * k);
    endfunction

    task automatic send(input int k);
        cap_valid = 1'b1;
        cap_pc    = rec_pc(k);
        cap_inst  = 32'(k);
        cap_wdata = ~32'(k);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic rd(input int a);
        rd_addr = AW'(a);
        tick();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; trig_pc = 32'hFFFF_FFFF; post_cnt = '0;
        cap_valid = 1'b0; cap_pc = '0; cap_inst = '0; cap_wdata = '0;
        rng_lo = '0; rng_hi = 32'hFFFF_FFFF; rd_addr = '0;
        tick(); tick();
        check("rst_state", state, 2'b00);
        check("rst_count", count, 0);
        check("rst_trig",  triggered, 0);
        check("rst_rdpc",  rd_pc, 0);
        reset = 1'b0;
        tick();

        // IDLE ignores records
        send(0);
        check("idle_count", count, 0);

        // pre-trigger capture, no match
        do_arm();
        for (int k = 0; k < 5; k++) send(k);
        check("pre_state", state, 2'b01);
        check("pre_count", count, 5);
        rd(0); check("pre_rd0_pc", rd_pc, 32'h0040_0000);
        rd(4); check("pre_rd4_pc", rd_pc, 32'h0040_0010);
        rd(2); check("pre_rd2_inst", rd_inst, 32'h2);
        check("pre_rd2_wdata", rd_wdata, 32'hFFFF_FFFD);

        // wraparound, trigger on record 11, post_cnt=0
        trig_pc = 32'h0040_002C; post_cnt = 4'd0;
        do_arm();
        for (int k = 0; k < 12; k++) send(k);
        check("wrap_state", state, 2'b11);
        check("wrap_count", count, 8);
        check("wrap_trig",  triggered, 1);
        rd(0); check("wrap_rd0_pc", rd_pc, 32'h0040_0010);
        rd(7); check("wrap_rd7_pc", rd_pc, 32'h0040_002C);
        send(12);
        check("done_count", count, 8);
        rd(7); check("done_rd7_pc", rd_pc, 32'h0040_002C);

        // trigger on record 3, post_cnt=3, with idle gaps
        trig_pc = 32'h0040_000C; post_cnt = 4'd3;
        do_arm();
        for (int k = 0; k < 4; k++) begin send(k); tick(); end
        check("post_state_a", state, 2'b10);
        send(4); tick(); send(5); tick();
        check("post_state_b", state, 2'b10);
        send(6);
        check("post_done_state", state, 2'b11);
        check("post_done_count", count, 7);
        send(7);
        check("post_frozen_count", count, 7);
        rd(3); check("post_trig_rec", rd_pc, 32'h0040_000C);

        // post_cnt clamped to DEPTH-1
        trig_pc = 32'h0040_0000; post_cnt = 4'd15;
        do_arm();
        for (int k = 0; k < 7; k++) send(k);
        check("clamp_state_a", state, 2'b10);
        send(7);
        check("clamp_state_b", state, 2'b11);
        check("clamp_count", count, 8);
        rd(0); check("clamp_rd0_pc", rd_pc, 32'h0040_0000);

        // arm and matching record in the same cycle
        trig_pc = 32'h0040_0000;
        arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'h0040_0000;
        tick();
        arm = 1'b0; cap_valid = 1'b0;
        check("armwin_state", state, 2'b01);
        check("armwin_count", count, 0);
        check("armwin_trig",  triggered, 0);

        // asynchronous reset mid-POST
        post_cnt = 4'd5;
        send(0); send(1);
        check("mid_state", state, 2'b10);
        rd(0); check("mid_rd0_pc", rd_pc, 32'h0040_0000);
        #2 reset = 1'b1;
        #1;
        check("arst_state", state, 2'b00);
        check("arst_count", count, 0);
        check("arst_trig",  triggered, 0);
        check("arst_rdpc",  rd_pc, 0);
        #1 reset = 1'b0;
        tick();

`ifdef TRACE_RANGE_EN
        rng_lo = 32'h0040_0008; rng_hi = 32'h0040_0010;
        trig_pc = 32'h0040_0004; post_cnt = 4'd0;
        do_arm();
        for (int k = 0; k < 6; k++) send(k);
        check("rng_count", count, 3);
        check("rng_state", state, 2'b01);
        check("rng_trig",  triggered, 0);
        rd(0); check("rng_rd0_pc", rd_pc, 32'h0040_0008);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
